// File: rtl/e_mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: op encodings, op classes, FSM states.
package e_mdu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] mdu_none  = 4'd0;
    localparam logic [OP_W-1:0] mdu_mult  = 4'd1;
    localparam logic [OP_W-1:0] mdu_multu = 4'd2;
    localparam logic [OP_W-1:0] mdu_div   = 4'd3;
    localparam logic [OP_W-1:0] mdu_divu  = 4'd4;
    localparam logic [OP_W-1:0] mdu_madd  = 4'd5;
    localparam logic [OP_W-1:0] mdu_maddu = 4'd6;
    localparam logic [OP_W-1:0] mdu_msub  = 4'd7;
    localparam logic [OP_W-1:0] mdu_msubu = 4'd8;
    localparam logic [OP_W-1:0] mdu_mthi  = 4'd9;
    localparam logic [OP_W-1:0] mdu_mtlo  = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [1:0] {
        OPC_NONE = 2'd0,
        OPC_MUL  = 2'd1,
        OPC_DIV  = 2'd2,
        OPC_MOVE = 2'd3
    } op_class_e;

    // Classify an op by latency group; unknown encodings behave as no-ops.
    function automatic op_class_e op_class(input logic [OP_W-1:0] op);
        op_class_e c;
        c = OPC_NONE;
        case (op)
            mdu_mult, mdu_multu, mdu_madd, mdu_maddu,
            mdu_msub, mdu_msubu:  c = OPC_MUL;
            mdu_div, mdu_divu:    c = OPC_DIV;
            mdu_mthi, mdu_mtlo:   c = OPC_MOVE;
            default:              c = OPC_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational datapath: 2*WIDTH multiply/accumulate and divide results for one op.
module e_mdu_calc
    import e_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]    op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] res_c,
    output logic               wr_en_c
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0]    a_sx, b_sx, a_zx, b_zx;
    logic [DW-1:0]    prod_s, prod_u;
    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag, b_mag_g, b_u_g;
    logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Sign/zero extension so low 2*WIDTH bits of the product are exact modulo 2^(2*WIDTH).
    assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign a_zx   = {{WIDTH{1'b0}}, a_i};
    assign b_zx   = {{WIDTH{1'b0}}, b_i};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide via magnitudes: truncates toward zero, and MIN/-1 wraps back to MIN with rem 0.
    assign b_zero  = (b_i == '0);
    assign a_neg   = a_i[WIDTH-1];
    assign b_neg   = b_i[WIDTH-1];
    assign a_mag   = a_neg ? -a_i : a_i;
    assign b_mag   = b_neg ? -b_i : b_i;
    assign b_mag_g = b_zero ? WIDTH'(1) : b_mag;
    assign b_u_g   = b_zero ? WIDTH'(1) : b_i;
    assign q_mag   = a_mag / b_mag_g;
    assign r_mag   = a_mag % b_mag_g;
    assign q_s     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r_s     = a_neg ? -r_mag : r_mag;
    assign q_u     = a_i / b_u_g;
    assign r_u     = a_i % b_u_g;

    // Select the result for the requested op; divide by zero suppresses the write.
    always_comb begin
        res_c   = acc_i;
        wr_en_c = 1'b0;
        case (op_i)
            mdu_mult:  begin res_c = prod_s;         wr_en_c = 1'b1;    end
            mdu_multu: begin res_c = prod_u;         wr_en_c = 1'b1;    end
            mdu_madd:  begin res_c = acc_i + prod_s; wr_en_c = 1'b1;    end
            mdu_maddu: begin res_c = acc_i + prod_u; wr_en_c = 1'b1;    end
            mdu_msub:  begin res_c = acc_i - prod_s; wr_en_c = 1'b1;    end
            mdu_msubu: begin res_c = acc_i - prod_u; wr_en_c = 1'b1;    end
            mdu_div:   begin res_c = {r_s, q_s};     wr_en_c = !b_zero; end
            mdu_divu:  begin res_c = {r_u, q_u};     wr_en_c = !b_zero; end
            default:   begin res_c = acc_i;          wr_en_c = 1'b0;    end
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle ops behind a start/busy handshake.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW      = 2 * WIDTH;
    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    pend_q, pend_d;
    logic             pend_wr_q, pend_wr_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d;

    logic [DW-1:0]    calc_res;
    logic             calc_wr;

    e_mdu_calc #(
        .WIDTH (WIDTH)
    ) u_calc (
        .op_i    (mdu_op),
        .a_i     (a),
        .b_i     (b),
        .acc_i   ({hi_q, lo_q}),
        .res_c   (calc_res),
        .wr_en_c (calc_wr)
    );

    // State, counter, pending result and HI/LO registers; reset aborts any in-flight op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
        end
    end

    // Accept ops in IDLE, count down in RUN, commit the pending result on the 1->0 step.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op_class(mdu_op))
                        OPC_MOVE: begin
                            if (mdu_op == mdu_mthi) hi_d = a;
                            else                    lo_d = a;
                        end
                        OPC_MUL: begin
                            state_d   = ST_RUN;
                            cnt_d     = CNT_W'(MUL_LAT);
                            pend_d    = calc_res;
                            pend_wr_d = calc_wr;
                        end
                        OPC_DIV: begin
                            state_d   = ST_RUN;
                            cnt_d     = CNT_W'(DIV_LAT);
                            pend_d    = calc_res;
                            pend_wr_d = calc_wr;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // A start here is a stall-logic bug upstream; it is deliberately ignored.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pend_wr_q) {hi_d, lo_d} = pend_q;
                    pend_d    = '0;
                    pend_wr_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
